// File: rtl/fpu_uart_frame_ctrl.sv
// rtl/fpu_uart_frame_ctrl.sv - UART request/response framer for the FPU datapath
// Receives opcode + two 32-bit operands, launches one FPU op, returns the result as 4 bytes.
module fpu_uart_frame_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_busy,
  input  logic [7:0]  data_out,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  data_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  opcode,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  output logic        busy,
  output logic        frame_error
);

  typedef enum logic [2:0] {
    RX_OP, RX_A, RX_B, FPU_GO, FPU_WAIT, TX_REQ, TX_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic        rx_busy_q;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [1:0]  opcode_q, opcode_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [2:0]  left_q, left_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        frame_error_q, frame_error_d;
  logic        byte_done;
  logic [2:0]  left_dec;

  assign byte_done = rx_busy_q & ~rx_busy;
  assign left_dec  = left_q - 3'd1;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_d         = tmo_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    opcode_d      = opcode_q;
    tx_sr_d       = tx_sr_q;
    left_d        = left_q;
    data_in_d     = data_in_q;
    frame_error_d = 1'b0;
    case (state_q)
      RX_OP: begin
        tmo_d = 32'd0;
        if (byte_done) begin
          if (data_out[7:2] == 6'd0) begin
            opcode_d   = data_out[1:0];
            byte_cnt_d = 2'd0;
            state_d    = RX_A;
          end else begin
            frame_error_d = 1'b1;
            data_in_d     = ERR_BYTE;
            left_d        = 3'd1;
            state_d       = TX_REQ;
          end
        end
      end
      RX_A, RX_B: begin
        // A received byte beats a simultaneous timeout terminal count.
        if (byte_done) begin
          tmo_d      = 32'd0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == RX_A) op_a_d = {op_a_q[23:0], data_out};
          else                 op_b_d = {op_b_q[23:0], data_out};
          if (byte_cnt_q == 2'd3) state_d = (state_q == RX_A) ? RX_B : FPU_GO;
        end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          frame_error_d = 1'b1;
          byte_cnt_d    = 2'd0;
          tmo_d         = 32'd0;
          state_d       = RX_OP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      FPU_GO: state_d = FPU_WAIT;
      FPU_WAIT: begin
        if (fpu_done) begin
          tx_sr_d   = fpu_result;
          left_d    = 3'd4;
          data_in_d = fpu_result[31:24];
          state_d   = TX_REQ;
        end
      end
      TX_REQ: begin
        if (tx_busy) state_d = TX_DONE;
      end
      TX_DONE: begin
        if (!tx_busy) begin
          left_d  = left_dec;
          tx_sr_d = tx_sr_q << 8;
          if (left_dec == 3'd0) begin
            state_d = RX_OP;
          end else begin
            data_in_d = tx_sr_q[23:16];
            state_d   = TX_REQ;
          end
        end
      end
      default: state_d = RX_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_OP;
      byte_cnt_q    <= 2'd0;
      tmo_q         <= 32'd0;
      rx_busy_q     <= 1'b0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      opcode_q      <= 2'd0;
      tx_sr_q       <= 32'd0;
      left_q        <= 3'd0;
      data_in_q     <= 8'h00;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_q         <= tmo_d;
      rx_busy_q     <= rx_busy;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      opcode_q      <= opcode_d;
      tx_sr_q       <= tx_sr_d;
      left_q        <= left_d;
      data_in_q     <= data_in_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign tx_en       = (state_q == TX_REQ);
  assign fpu_start   = (state_q == FPU_GO);
  assign busy        = !((state_q == RX_OP) && (byte_cnt_q == 2'd0));
  assign data_in     = data_in_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign opcode      = opcode_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_fpu_uart_frame_ctrl.sv
// tb/tb_fpu_uart_frame_ctrl.sv - scoreboard bench for fpu_uart_frame_ctrl
module tb_fpu_uart_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_busy;
  logic [7:0]  data_out;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  data_in;
  logic [31:0] op_a, op_b;
  logic [1:0]  opcode;
  logic        fpu_start;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        busy;
  logic        frame_error;

  fpu_uart_frame_ctrl #(.TIMEOUT_CYCLES(32'd100), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .reset(reset), .rx_busy(rx_busy), .data_out(data_out),
    .tx_busy(tx_busy), .tx_en(tx_en), .data_in(data_in), .op_a(op_a),
    .op_b(op_b), .opcode(opcode), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .busy(busy),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } op_t;

  op_t        op_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0, n_errors = 0;
  int fs_cnt = 0, fe_cnt = 0, tx_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse counters
  initial forever begin
    @(posedge clk); #1;
    if (frame_error) fe_cnt++;
  end

  // UART transmitter model
  initial begin
    logic [7:0] e;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_en && !tx_busy) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          check_val("tx_unexpected", tx_en, 1'b0);
        end else begin
          e = tx_q.pop_front();
          check_val("tx_byte", data_in, e);
        end
        @(negedge clk); tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // FPU model
  initial begin
    op_t  e;
    logic early;
    fpu_done = 1'b0;
    fpu_result = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (fpu_start) begin
        fs_cnt++;
        if (op_q.size() == 0) begin
          check_val("fpu_unexpected", fpu_start, 1'b0);
        end else begin
          e = op_q.pop_front();
          check_val("opcode", opcode, e.opc);
          check_val("op_a", op_a, e.a);
          check_val("op_b", op_b, e.b);
          early = 1'b0;
          repeat (e.lat) begin
            @(posedge clk); #1;
            if (tx_en || fpu_start) early = 1'b1;
          end
          check_val("tx_before_done", early, 1'b0);
          check_val("op_a_hold", op_a, e.a);
          @(negedge clk); fpu_done = 1'b1; fpu_result = e.res;
          @(posedge clk); #1;
          check_val("tx_en_latency", tx_en, 1'b1);
          @(negedge clk); fpu_done = 1'b0; fpu_result = 32'd0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_busy = 1'b1; data_out = b;
    repeat (3) @(negedge clk);
    rx_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input int lat);
    logic [7:0] fr[9];
    op_t o;
    o.opc = opc; o.a = a; o.b = b; o.res = res; o.lat = lat;
    op_q.push_back(o);
    for (int i = 0; i < 4; i++) tx_q.push_back(res[31-8*i -: 8]);
    fr[0] = {6'd0, opc};
    for (int i = 0; i < 4; i++) begin
      fr[1+i] = a[31-8*i -: 8];
      fr[5+i] = b[31-8*i -: 8];
    end
    for (int i = 0; i < 9; i++) send_byte(fr[i]);
    check_val("fpu_start_latency", fpu_start, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (!busy && !tx_busy && tx_q.size() == 0 && op_q.size() == 0) break;
    end
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_txq"}, tx_q.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0, fe0, tx0;
    reset = 1'b1; rx_busy = 1'b0; data_out = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx_en", tx_en, 1'b0);
    check_val("rst_data_in", data_in, 8'h00);
    check_val("rst_op_a", op_a, 32'd0);
    check_val("rst_op_b", op_b, 32'd0);
    check_val("rst_opcode", opcode, 2'd0);
    check_val("rst_fpu_start", fpu_start, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_frame_error", frame_error, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Add
    fs0 = fs_cnt;
    send_frame(2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 2);
    wait_idle("add");
    check_val("add_starts", fs_cnt - fs0, 1);

    // Div with slow FPU
    send_frame(2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 50);
    wait_idle("div");

    // Invalid opcode, then a valid subtract
    fs0 = fs_cnt; fe0 = fe_cnt;
    tx_q.push_back(8'hEE);
    send_byte(8'h07);
    wait_idle("badop");
    check_val("badop_frame_error", fe_cnt - fe0, 1);
    check_val("badop_no_start", fs_cnt - fs0, 0);
    send_frame(2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 3);
    wait_idle("sub");

    // Timeout after a partial frame; op_a keeps its shifted partial value
    fe0 = fe_cnt; tx0 = tx_cnt;
    send_byte(8'h02); send_byte(8'h3F); send_byte(8'h80);
    repeat (95) @(posedge clk);
    #2;
    check_val("tmo_not_early", busy, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    check_val("tmo_frame_error", fe_cnt - fe0, 1);
    check_val("tmo_busy", busy, 1'b0);
    check_val("tmo_op_a_partial", op_a, 32'h00003F80);
    check_val("tmo_no_tx", tx_cnt - tx0, 0);
    send_frame(2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 2);
    wait_idle("mul");

    // Reset during the 2nd result byte
    tx0 = tx_cnt;
    send_frame(2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 2);
    for (int i = 0; i < 2000 && tx_cnt < tx0 + 2; i++) begin
      @(posedge clk); #2;
    end
    check_val("rst_mid_tx_reached", tx_cnt - tx0, 2);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_tx_en", tx_en, 1'b0);
    check_val("midrst_data_in", data_in, 8'h00);
    check_val("midrst_op_a", op_a, 32'd0);
    check_val("midrst_busy", busy, 1'b0);
    @(negedge clk); reset = 1'b0;
    tx_q.delete();
    repeat (8) @(posedge clk);
    send_frame(2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 2);
    wait_idle("after_rst");

    // Back-to-back with an early byte dropped during FPU wait
    fs0 = fs_cnt; tx0 = tx_cnt;
    send_frame(2'd1, 32'h40A00000, 32'h3F800000, 32'h40800000, 20);
    send_byte(8'h03);
    wait_idle("b2b_1");
    send_frame(2'd3, 32'h41000000, 32'h40000000, 32'h40800000, 2);
    wait_idle("b2b_2");
    check_val("b2b_starts", fs_cnt - fs0, 2);
    check_val("b2b_tx_bytes", tx_cnt - tx0, 8);

    check_val("op_q_empty", op_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
